// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter slice.
//
// Contents:
//   XLEN, REG_ADDR_W, NUM_REGS : register-file geometry (32 x 32-bit, 5-bit index)
//   arb_state_t                : arbiter FSM states (CLEAR sweep, RUN arbitration)
//   reg_addr_t                 : register index type
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_t;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker with its own priority pointer.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (pointer returns to 0)
//   req      in   NUM_REQ request vector
//   advance  in   a grant was consumed this cycle; move pointer past the grantee
//   gnt      out  one-hot-or-zero grant vector
//   gnt_idx  out  index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;
    int               cand;

    // Scan from the pointer, wrapping around, and take the first asserted request.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr_q) + off) % NUM_REQ;
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = IDX_W'(cand);
            end
        end
    end

    // The requester right after the grantee gets top priority next time;
    // NUM_REQ need not be a power of two, so wrap explicitly.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            if (gnt_idx == IDX_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between NUM_REQ write-back
// sources using round-robin arbitration and a valid/ready handshake.
// Writes to x00 are accepted but never reach the register file.
//
// Optional feature (macro REGFILE_CLEAR_ON_RESET_EN): after reset the block
// first sweeps zeros into x01..x31, since the register file has no reset.
// Without the macro the block arbitrates straight out of reset.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   req_valid   per-requester write pending
//   req_addr    per-requester destination index (packed, [i])
//   req_data    per-requester write data (packed, [i])
//   req_ready   one-hot-or-zero grant; accept on valid & ready
//   wr_ena      register-file write enable
//   wr_addr     register-file write address
//   wr_data     register-file write data
//   grant_id    index of current grantee, 0 when idle
//   init_done   high once arbitration is running
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][XLEN-1:0]         req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 wr_ena,
    output logic [REG_ADDR_W-1:0]                wr_addr,
    output logic [XLEN-1:0]                      wr_data,
    output logic [IDX_W-1:0]                     grant_id,
    output logic                                 init_done
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("regfile_write_arbiter: NUM_REQ must be within 2..8");
    end

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gntIdx;
    logic               anyGnt;
    logic               inRun;
    logic               advance;

`ifdef REGFILE_CLEAR_ON_RESET_EN
    arb_state_t state_q;
    arb_state_t state_d;
    reg_addr_t  clrIdx_q;
    reg_addr_t  clrIdx_d;
    logic       inClear;

    // Sweep walks x01..x31 one per cycle, then hands over to arbitration.
    always_comb begin
        state_d  = state_q;
        clrIdx_d = clrIdx_q;
        if (state_q == CLEAR) begin
            clrIdx_d = clrIdx_q + reg_addr_t'(1);
            if (clrIdx_q == reg_addr_t'(NUM_REGS - 1)) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR;
            clrIdx_q <= reg_addr_t'(1);
        end else begin
            state_q  <= state_d;
            clrIdx_q <= clrIdx_d;
        end
    end

    assign inClear = (state_q == CLEAR);
    assign inRun   = (state_q == RUN);
`else
    assign inRun = 1'b1;
`endif

    assign anyGnt  = |gnt;
    assign advance = !rst && inRun && anyGnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (advance),
        .gnt     (gnt),
        .gnt_idx (gntIdx)
    );

    // Output mux. Reset forces everything low immediately so a write in
    // flight is dropped rather than half-completed. A grant to x00 still
    // handshakes but leaves wr_ena low.
    always_comb begin
        req_ready = '0;
        wr_ena    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        grant_id  = '0;
        if (!rst) begin
`ifdef REGFILE_CLEAR_ON_RESET_EN
            if (inClear) begin
                wr_ena  = 1'b1;
                wr_addr = clrIdx_q;
            end else
`endif
            if (anyGnt) begin
                req_ready = gnt;
                grant_id  = gntIdx;
                wr_addr   = req_addr[gntIdx];
                wr_data   = req_data[gntIdx];
                wr_ena    = (req_addr[gntIdx] != '0);
            end
        end
    end

    assign init_done = !rst && inRun;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter with NUM_REQ = 2.
// Works with and without REGFILE_CLEAR_ON_RESET_EN defined.
module tb_regfile_write_arbiter;

    localparam int N = 2;
`ifdef REGFILE_CLEAR_ON_RESET_EN
    localparam int CLEAR_LEN = 31;
`else
    localparam int CLEAR_LEN = 0;
`endif

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0][4:0]    req_addr;
    logic [N-1:0][31:0]   req_data;
    logic [N-1:0]         req_ready;
    logic                 wr_ena;
    logic [4:0]           wr_addr;
    logic [31:0]          wr_data;
    logic [0:0]           grant_id;
    logic                 init_done;

    regfile_write_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_ena    (wr_ena),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file driven by the DUT write port.
    logic [31:0] rf    [32] = '{default: 32'hBAD0BAD0};
    logic [31:0] expRf [32] = '{default: 32'hBAD0BAD0};

    always @(posedge clk) begin
        if (wr_ena) rf[wr_addr] <= wr_data;
    end

    int checks     = 0;
    int failures   = 0;
    int mPtr       = 0;
    int mClearLeft = CLEAR_LEN;
    int lastWinner = -1;

    typedef struct {
        string       tag;
        logic [1:0]  valid;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  eReady;
        int          eGrant;
        logic        eEna;
        logic [4:0]  eAddr;
        logic [31:0] eData;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] v,
                                 input logic [4:0] a0, input logic [4:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clk);
        rst         = r;
        req_valid   = v;
        req_addr[0] = a0;
        req_addr[1] = a1;
        req_data[0] = d0;
        req_data[1] = d1;
        #1;
    endtask

    // Reference: winner is the valid requester at the smallest circular
    // distance from the pointer.
    task automatic modelOutputs(output logic [1:0] eReady, output int eGrant,
                                output logic eEna, output logic [4:0] eAddr,
                                output logic [31:0] eData, output logic eInit,
                                output int winner);
        int bestDist;
        eReady = '0; eGrant = 0; eEna = 1'b0; eAddr = '0; eData = '0;
        eInit = 1'b0; winner = -1; bestDist = N;
        if (rst) return;
        if (mClearLeft > 0) begin
            eEna  = 1'b1;
            eAddr = 5'(32 - mClearLeft);
            return;
        end
        eInit = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && ((i - mPtr + N) % N) < bestDist) begin
                bestDist = (i - mPtr + N) % N;
                winner   = i;
            end
        end
        if (winner >= 0) begin
            eReady[winner] = 1'b1;
            eGrant         = winner;
            eAddr          = req_addr[winner];
            eData          = req_data[winner];
            eEna           = (req_addr[winner] != 5'd0);
        end
    endtask

    task automatic finishCycle(input int winner, input logic eEna,
                               input logic [4:0] eAddr, input logic [31:0] eData);
        @(posedge clk);
        if (rst) begin
            mPtr       = 0;
            mClearLeft = CLEAR_LEN;
        end else if (mClearLeft > 0) begin
            mClearLeft--;
        end else if (winner >= 0) begin
            mPtr = (winner + 1) % N;
        end
        if (eEna) expRf[eAddr] = eData;
        lastWinner = winner;
    endtask

    task automatic checkCycle(input string tag);
        logic [1:0]  eReady;
        int          eGrant;
        logic        eEna;
        logic [4:0]  eAddr;
        logic [31:0] eData;
        logic        eInit;
        int          winner;
        modelOutputs(eReady, eGrant, eEna, eAddr, eData, eInit, winner);
        checkOutput({tag, ".ready"}, 32'(req_ready), 32'(eReady));
        checkOutput({tag, ".grant"}, 32'(grant_id),  32'(eGrant));
        checkOutput({tag, ".ena"},   32'(wr_ena),    32'(eEna));
        checkOutput({tag, ".addr"},  32'(wr_addr),   32'(eAddr));
        checkOutput({tag, ".data"},  wr_data,        eData);
        checkOutput({tag, ".init"},  32'(init_done), 32'(eInit));
        finishCycle(winner, eEna, eAddr, eData);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  eReady;
        int          eGrant;
        logic        eEna;
        logic [4:0]  eAddr;
        logic [31:0] eData;
        logic        eInit;
        int          winner;
        logic [1:0]  v;
        logic [4:0]  ra [2];
        logic [31:0] rd [2];
        logic        r;

        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        vecs[0] = '{"wr05",    2'b01, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        2'b01, 0, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{"both_a",  2'b11, 5'd3, 5'd4,  32'hA0000001, 32'hB0000001, 2'b10, 1, 1'b1, 5'd4,  32'hB0000001};
        vecs[2] = '{"both_b",  2'b11, 5'd3, 5'd4,  32'hA0000001, 32'hB0000002, 2'b01, 0, 1'b1, 5'd3,  32'hA0000001};
        vecs[3] = '{"both_c",  2'b11, 5'd3, 5'd4,  32'hA0000002, 32'hB0000002, 2'b10, 1, 1'b1, 5'd4,  32'hB0000002};
        vecs[4] = '{"both_d",  2'b11, 5'd3, 5'd4,  32'hA0000002, 32'hB0000003, 2'b01, 0, 1'b1, 5'd3,  32'hA0000002};
        vecs[5] = '{"tail_b",  2'b10, 5'd0, 5'd4,  32'h0,        32'hB0000003, 2'b10, 1, 1'b1, 5'd4,  32'hB0000003};
        vecs[6] = '{"x0",      2'b10, 5'd0, 5'd0,  32'h0,        32'h00001234, 2'b10, 1, 1'b0, 5'd0,  32'h00001234};
        vecs[7] = '{"afterx0", 2'b11, 5'd9, 5'd10, 32'h00000090, 32'h00000100, 2'b01, 0, 1'b1, 5'd9,  32'h00000090};
        vecs[8] = '{"idle",    2'b00, 5'd9, 5'd10, 32'h00000090, 32'h00000100, 2'b00, 0, 1'b0, 5'd0,  32'h0};
        vecs[9] = '{"ptrkeep", 2'b11, 5'd9, 5'd10, 32'h00000091, 32'h00000100, 2'b10, 1, 1'b1, 5'd10, 32'h00000100};

        // Reset held two cycles with requests pending: everything must stay low.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 2'b11, 5'd3, 5'd4, 32'h11, 32'h22);
            checkCycle($sformatf("rst%0d", k));
        end

`ifdef REGFILE_CLEAR_ON_RESET_EN
        // Zero sweep with requests pending; no grants may leak out.
        for (int k = 0; k < 31; k++) begin
            applyStimulus(1'b0, 2'b11, 5'd3, 5'd4, 32'h11, 32'h22);
            checkCycle($sformatf("sweep%0d", k));
        end
        #1;
        for (int k = 1; k < 32; k++) begin
            checkOutput($sformatf("sweep.x%0d", k), rf[k], 32'h0);
        end
`endif

        // Directed table; first entry lands on the first cycle arbitration is live.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            checkOutput({vecs[i].tag, ".ready"}, 32'(req_ready), 32'(vecs[i].eReady));
            checkOutput({vecs[i].tag, ".grant"}, 32'(grant_id),  32'(vecs[i].eGrant));
            checkOutput({vecs[i].tag, ".ena"},   32'(wr_ena),    32'(vecs[i].eEna));
            checkOutput({vecs[i].tag, ".addr"},  32'(wr_addr),   32'(vecs[i].eAddr));
            checkOutput({vecs[i].tag, ".data"},  wr_data,        vecs[i].eData);
            checkOutput({vecs[i].tag, ".init"},  32'(init_done), 32'h1);
            modelOutputs(eReady, eGrant, eEna, eAddr, eData, eInit, winner);
            finishCycle(winner, eEna, eAddr, eData);
        end

        applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        checkOutput("rd.x05", rf[5],  32'hDEADBEEF);
        checkOutput("rd.x03", rf[3],  32'hA0000002);
        checkOutput("rd.x04", rf[4],  32'hB0000003);
        checkOutput("rd.x09", rf[9],  32'h00000090);
        checkOutput("rd.x10", rf[10], 32'h00000100);
        checkOutput("rd.x00", rf[0],  32'hBAD0BAD0);
        checkCycle("idle2");

`ifdef REGFILE_CLEAR_ON_RESET_EN
        // Reset landing in the middle of the sweep (at x12) must restart it at x01.
        applyStimulus(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        checkCycle("mid.rst");
        for (int k = 0; k < 11; k++) begin
            applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
            checkCycle($sformatf("mid.pre%0d", k));
        end
        applyStimulus(1'b1, 2'b01, 5'd7, 5'd0, 32'h77, 32'h0);
        checkCycle("mid.at12");
        for (int k = 0; k < 32; k++) begin
            applyStimulus(1'b0, 2'b01, 5'd7, 5'd0, 32'h77, 32'h0);
            checkCycle($sformatf("mid.post%0d", k));
        end
`endif

        // Randomised traffic with occasional resets; a pending request holds
        // its address and data until accepted.
        v = '0;
        ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 2) != 0) begin
                    v[i]  = 1'b1;
                    ra[i] = 5'($urandom_range(0, 15));
                    rd[i] = $urandom;
                end
            end
            applyStimulus(r, v, ra[0], ra[1], rd[0], rd[1]);
            checkCycle($sformatf("rnd%0d", cyc));
            if (lastWinner >= 0) v[lastWinner] = 1'b0;
        end

        applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("final.x%0d", k), rf[k], expRf[k]);
        end
        checkCycle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
